// File: rtl/hawk_pgrd_seq.sv
// hawk_pgrd_seq: resolves ATT lookups to a physical page. On a miss it pulls a free
// way, or hands off to the compress/decompress/compact managers and forwards their traffic.
module hawk_pgrd_seq #(
  parameter int AW = 64,
  parameter int DW = 512,
  parameter int LW = 16,
  parameter logic [AW-13:0] HPPA_BASE_PG = 'h80000,
  parameter logic [AW-1:0] ATT_BASE = 'h0,
  parameter logic [AW-1:0] TOL_BASE = 'h100000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            lookup,
  input  logic [AW-13:0]  lookup_hppa,
  input  logic [1:0]      sw_ctrl,
  input  logic [LW-1:0]   free_head,
  input  logic [LW-1:0]   unc_head,
  input  logic [LW-1:0]   unc_tail,
  input  logic            arready,
  input  logic            rvalid,
  input  logic            rlast,
  input  logic [1:0]      rresp,
  input  logic [DW-1:0]   rdata,
  output logic [AW-1:0]   ar_addr,
  output logic [7:0]      arlen,
  output logic            arvalid,
  output logic            rready,
  input  logic            pgwr_ready,
  input  logic            tbl_update_done,
  output logic            tol_update,
  output logic [LW-1:0]   tol_att_id,
  output logic [AW-13:0]  tol_way,
  output logic [AW-1:0]   trnsl_ppa,
  output logic [1:0]      trnsl_sts,
  output logic            allow_access,
  output logic            comp_trig,
  input  logic            comp_done,
  input  logic [AW-13:0]  comp_freeway,
  output logic            decomp_trig,
  input  logic            decomp_done,
  output logic [AW-1:0]   decomp_freeway,
  output logic [AW-13:0]  decomp_src_pg,
  input  logic            compact_req,
  output logic            compact_trig,
  input  logic            compact_done,
  input  logic [AW-1:0]   c_ar_addr,
  input  logic [7:0]      c_arlen,
  input  logic            c_arvalid,
  input  logic            c_rready,
  input  logic            c_tol_update,
  input  logic [LW-1:0]   c_tol_att_id,
  input  logic [AW-13:0]  c_tol_way,
  input  logic            c_rdm_reset,
  input  logic [AW-1:0]   d_ar_addr,
  input  logic [7:0]      d_arlen,
  input  logic            d_arvalid,
  input  logic            d_rready,
  input  logic            d_tol_update,
  input  logic [LW-1:0]   d_tol_att_id,
  input  logic [AW-13:0]  d_tol_way,
  input  logic            d_rdm_reset,
  input  logic [AW-1:0]   k_ar_addr,
  input  logic [7:0]      k_arlen,
  input  logic            k_arvalid,
  input  logic            k_rready,
  input  logic            k_tol_update,
  input  logic [LW-1:0]   k_tol_att_id,
  input  logic [AW-13:0]  k_tol_way,
  input  logic            k_rdm_reset,
  output logic            rdm_reset,
  output logic            ready,
  output logic            alert_oom,
  output logic [4:0]      state
);

  localparam logic [1:0] UNCOMP = 2'd1;
  localparam logic [1:0] COMP   = 2'd2;
  localparam logic [1:0] INCOMP = 2'd3;

  typedef enum logic [4:0] {
    S_IDLE, S_LOOKUP_ATT, S_WAIT_ATT, S_DECODE_ATT, S_CHK_ATT, S_POP_FREE,
    S_WAIT_LST, S_DECODE_LST, S_WAIT_DCMP, S_ALLOCATE, S_TBL_UPDATE, S_TBL_DONE,
    S_COMPRESS, S_DECOMPRESS, S_WAIT_TBL, S_COMPACT, S_BUS_ERROR
  } state_t;

  typedef struct packed {
    logic [AW-1:0]  ar_addr;
    logic [7:0]     arlen;
    logic           arvalid;
    logic           rready;
    logic           tol_update;
    logic [LW-1:0]  tol_att_id;
    logic [AW-13:0] tol_way;
    logic           rdm_reset;
  } grp_t;

  typedef struct packed {
    grp_t           bus;
    logic [AW-1:0]  trnsl_ppa;
    logic [1:0]     trnsl_sts;
    logic           allow_access;
    logic           comp_trig;
    logic           decomp_trig;
    logic           compact_trig;
    logic [AW-1:0]  decomp_freeway;
    logic [AW-13:0] decomp_src_pg;
    logic           ready;
    logic           alert_oom;
    logic [LW-1:0]  att_id;
    logic           from_free;
    logic [1:0]     rd_sts;
    logic [AW-13:0] rd_way;
    logic [1:0]     sts;
    logic [AW-13:0] way;
    logic [LW-1:0]  saved_att_id;
    logic [AW-13:0] saved_way;
  } regs_t;

  state_t state_reg, state_next;
  regs_t r_reg, r_next;
  grp_t grp_c, grp_d, grp_k, grp_sel;
  logic mirror;
  logic rd_ok, rd_done;
  logic [AW-13:0] pg_diff;
  logic unused_bits;

  assign grp_c = {c_ar_addr, c_arlen, c_arvalid, c_rready, c_tol_update, c_tol_att_id, c_tol_way, c_rdm_reset};
  assign grp_d = {d_ar_addr, d_arlen, d_arvalid, d_rready, d_tol_update, d_tol_att_id, d_tol_way, d_rdm_reset};
  assign grp_k = {k_ar_addr, k_arlen, k_arvalid, k_rready, k_tol_update, k_tol_att_id, k_tol_way, k_rdm_reset};
  assign mirror  = (state_reg == S_COMPRESS) || (state_reg == S_DECOMPRESS) || (state_reg == S_COMPACT);
  assign grp_sel = (state_reg == S_COMPRESS) ? grp_c : (state_reg == S_DECOMPRESS) ? grp_d : grp_k;

  assign rd_done = rvalid && rlast;
  assign rd_ok   = rd_done && (rresp == 2'b00);
  assign pg_diff = lookup_hppa - HPPA_BASE_PG + {{(AW-13){1'b0}}, 1'b1};
  assign unused_bits = ^{rdata[DW-1:64], rdata[61:52], sw_ctrl[0], pg_diff[AW-13:LW]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (lookup)                           state_next = S_LOOKUP_ATT;
        else if (compact_req && sw_ctrl[1])   state_next = S_COMPACT;
      end
      S_LOOKUP_ATT: if (arready && !r_reg.bus.arvalid) state_next = S_WAIT_ATT;
      S_WAIT_ATT:   if (rd_done) state_next = rd_ok ? S_DECODE_ATT : S_BUS_ERROR;
      S_DECODE_ATT: state_next = S_CHK_ATT;
      S_CHK_ATT:    state_next = (r_reg.sts == UNCOMP || r_reg.sts == INCOMP) ? S_IDLE : S_POP_FREE;
      S_POP_FREE: begin
        if (free_head != '0)          state_next = S_WAIT_LST;
        else if (unc_tail != unc_head) state_next = S_COMPRESS;
        else                          state_next = S_IDLE;
      end
      S_WAIT_LST:   if (rd_done) state_next = rd_ok ? S_DECODE_LST : S_BUS_ERROR;
      S_DECODE_LST: state_next = (r_reg.sts == COMP) ? S_WAIT_DCMP : S_ALLOCATE;
      S_WAIT_DCMP:  state_next = S_DECOMPRESS;
      S_ALLOCATE:   state_next = S_TBL_UPDATE;
      S_TBL_UPDATE: if (pgwr_ready) state_next = S_TBL_DONE;
      S_TBL_DONE:   if (tbl_update_done) state_next = S_IDLE;
      S_COMPRESS:   if (comp_done) state_next = (r_reg.sts == COMP) ? S_DECOMPRESS : S_IDLE;
      S_DECOMPRESS: if (decomp_done) state_next = r_reg.from_free ? S_WAIT_TBL : S_IDLE;
      S_WAIT_TBL:   state_next = S_TBL_UPDATE;
      S_COMPACT:    if (compact_done) state_next = S_IDLE;
      S_BUS_ERROR:  state_next = S_BUS_ERROR;
      default:      state_next = S_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_reg;
    r_next.bus.arvalid    = 1'b0;
    r_next.bus.arlen      = 8'd0;
    r_next.bus.rready     = 1'b1;
    r_next.bus.tol_update = 1'b0;
    r_next.bus.rdm_reset  = 1'b0;
    r_next.allow_access   = 1'b0;
    r_next.comp_trig      = (state_next == S_COMPRESS);
    r_next.decomp_trig    = (state_next == S_DECOMPRESS);
    r_next.compact_trig   = (state_next == S_COMPACT);
    r_next.ready          = (state_next == S_IDLE);
    // Sub-manager owns the bus while its trigger is up
    if (mirror) r_next.bus = grp_sel;
    case (state_reg)
      S_IDLE: if (lookup) r_next.att_id = pg_diff[LW-1:0];
      S_LOOKUP_ATT: begin
        if (arready && !r_reg.bus.arvalid) begin
          r_next.bus.ar_addr = ATT_BASE + AW'({r_reg.att_id, 3'b000});
          r_next.bus.arvalid = 1'b1;
        end
      end
      S_WAIT_ATT, S_WAIT_LST: begin
        if (rd_ok) begin
          r_next.rd_sts = rdata[63:62];
          r_next.rd_way = rdata[AW-13:0];
        end
      end
      S_DECODE_ATT: begin
        r_next.sts = r_reg.rd_sts;
        r_next.way = r_reg.rd_way;
      end
      S_CHK_ATT: begin
        if (r_reg.sts == UNCOMP || r_reg.sts == INCOMP) begin
          r_next.trnsl_ppa    = {r_reg.way, 12'h000};
          r_next.trnsl_sts    = r_reg.sts;
          r_next.allow_access = 1'b1;
        end
      end
      S_POP_FREE: begin
        if (free_head != '0) begin
          r_next.bus.ar_addr = TOL_BASE + AW'({free_head, 3'b000});
          r_next.bus.arvalid = 1'b1;
        end else if (unc_tail == unc_head) begin
          r_next.alert_oom = 1'b1;
        end
      end
      S_DECODE_LST: begin
        r_next.bus.tol_att_id = r_reg.att_id;
        r_next.bus.tol_way    = r_reg.rd_way;
        r_next.saved_att_id   = r_reg.att_id;
        r_next.saved_way      = r_reg.rd_way;
        r_next.from_free      = 1'b1;
        if (r_reg.sts == COMP) begin
          r_next.decomp_freeway = {r_reg.rd_way, 12'h000};
          r_next.decomp_src_pg  = r_reg.way;
        end
      end
      S_ALLOCATE: begin
        r_next.trnsl_ppa = {r_reg.bus.tol_way, 12'h000};
        r_next.trnsl_sts = UNCOMP;
      end
      S_TBL_UPDATE: if (pgwr_ready) r_next.bus.tol_update = 1'b1;
      S_TBL_DONE:   if (tbl_update_done) r_next.allow_access = 1'b1;
      S_COMPRESS: begin
        if (comp_done) begin
          r_next.from_free = 1'b0;
          if (r_reg.sts == COMP) begin
            r_next.decomp_freeway = {comp_freeway, 12'h000};
            r_next.decomp_src_pg  = r_reg.way;
          end else begin
            r_next.trnsl_ppa    = {comp_freeway, 12'h000};
            r_next.trnsl_sts    = UNCOMP;
            r_next.allow_access = 1'b1;
          end
        end
      end
      S_DECOMPRESS: begin
        if (decomp_done) begin
          r_next.trnsl_ppa    = r_reg.decomp_freeway;
          r_next.trnsl_sts    = UNCOMP;
          r_next.allow_access = !r_reg.from_free;
        end
      end
      // Decompressor may have scribbled on tol_*; put back the free-list packet
      S_WAIT_TBL: begin
        r_next.bus.tol_att_id = r_reg.saved_att_id;
        r_next.bus.tol_way    = r_reg.saved_way;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_reg             <= '0;
      r_reg.bus.ar_addr <= ATT_BASE;
      r_reg.ready       <= 1'b1;
    end else begin
      r_reg <= r_next;
    end
  end

  assign ar_addr        = r_reg.bus.ar_addr;
  assign arlen          = r_reg.bus.arlen;
  assign arvalid        = r_reg.bus.arvalid;
  assign rready         = r_reg.bus.rready;
  assign tol_update     = r_reg.bus.tol_update;
  assign tol_att_id     = r_reg.bus.tol_att_id;
  assign tol_way        = r_reg.bus.tol_way;
  assign rdm_reset      = r_reg.bus.rdm_reset;
  assign trnsl_ppa      = r_reg.trnsl_ppa;
  assign trnsl_sts      = r_reg.trnsl_sts;
  assign allow_access   = r_reg.allow_access;
  assign comp_trig      = r_reg.comp_trig;
  assign decomp_trig    = r_reg.decomp_trig;
  assign compact_trig   = r_reg.compact_trig;
  assign decomp_freeway = r_reg.decomp_freeway;
  assign decomp_src_pg  = r_reg.decomp_src_pg;
  assign ready          = r_reg.ready;
  assign alert_oom      = r_reg.alert_oom;
  assign state          = state_reg;

endmodule

// File: tb/tb_hawk_pgrd_seq.sv
// Bench for hawk_pgrd_seq: directed and random lookups against a page-resolution model,
// with the bench acting as AXI memory and as the three sub-managers.
module tb_hawk_pgrd_seq;
  localparam int AW = 64, DW = 512, LW = 16;
  localparam logic [51:0] HBASE = 52'h80000;
  localparam logic [63:0] TOLB  = 64'h100000;
  localparam int W_ARV = 0, W_ALLOW = 1, W_TOLUPD = 2, W_CTRIG = 3, W_DTRIG = 4, W_KTRIG = 5, W_READY = 6;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic lookup = 0; logic [51:0] lookup_hppa = '0; logic [1:0] sw_ctrl = '0;
  logic [15:0] free_head = '0, unc_head = '0, unc_tail = '0;
  logic arready = 1'b1, rvalid = 0, rlast = 0; logic [1:0] rresp = '0; logic [DW-1:0] rdata = '0;
  logic [63:0] ar_addr; logic [7:0] arlen; logic arvalid, rready;
  logic pgwr_ready = 1'b1, tbl_update_done = 0;
  logic tol_update; logic [15:0] tol_att_id; logic [51:0] tol_way;
  logic [63:0] trnsl_ppa; logic [1:0] trnsl_sts; logic allow_access;
  logic comp_trig, comp_done = 0; logic [51:0] comp_freeway = '0;
  logic decomp_trig, decomp_done = 0; logic [63:0] decomp_freeway; logic [51:0] decomp_src_pg;
  logic compact_req = 0, compact_trig, compact_done = 0;
  logic [63:0] g_ar_addr [3]; logic [7:0] g_arlen [3]; logic g_arvalid [3]; logic g_rready [3];
  logic g_tol_update [3]; logic [15:0] g_tol_att_id [3]; logic [51:0] g_tol_way [3]; logic g_rdm_reset [3];
  logic rdm_reset, ready, alert_oom; logic [4:0] state;

  hawk_pgrd_seq #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .lookup(lookup), .lookup_hppa(lookup_hppa), .sw_ctrl(sw_ctrl),
    .free_head(free_head), .unc_head(unc_head), .unc_tail(unc_tail),
    .arready(arready), .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rdata(rdata),
    .ar_addr(ar_addr), .arlen(arlen), .arvalid(arvalid), .rready(rready),
    .pgwr_ready(pgwr_ready), .tbl_update_done(tbl_update_done),
    .tol_update(tol_update), .tol_att_id(tol_att_id), .tol_way(tol_way),
    .trnsl_ppa(trnsl_ppa), .trnsl_sts(trnsl_sts), .allow_access(allow_access),
    .comp_trig(comp_trig), .comp_done(comp_done), .comp_freeway(comp_freeway),
    .decomp_trig(decomp_trig), .decomp_done(decomp_done), .decomp_freeway(decomp_freeway),
    .decomp_src_pg(decomp_src_pg), .compact_req(compact_req), .compact_trig(compact_trig),
    .compact_done(compact_done),
    .c_ar_addr(g_ar_addr[0]), .c_arlen(g_arlen[0]), .c_arvalid(g_arvalid[0]), .c_rready(g_rready[0]),
    .c_tol_update(g_tol_update[0]), .c_tol_att_id(g_tol_att_id[0]), .c_tol_way(g_tol_way[0]), .c_rdm_reset(g_rdm_reset[0]),
    .d_ar_addr(g_ar_addr[1]), .d_arlen(g_arlen[1]), .d_arvalid(g_arvalid[1]), .d_rready(g_rready[1]),
    .d_tol_update(g_tol_update[1]), .d_tol_att_id(g_tol_att_id[1]), .d_tol_way(g_tol_way[1]), .d_rdm_reset(g_rdm_reset[1]),
    .k_ar_addr(g_ar_addr[2]), .k_arlen(g_arlen[2]), .k_arvalid(g_arvalid[2]), .k_rready(g_rready[2]),
    .k_tol_update(g_tol_update[2]), .k_tol_att_id(g_tol_att_id[2]), .k_tol_way(g_tol_way[2]), .k_rdm_reset(g_rdm_reset[2]),
    .rdm_reset(rdm_reset), .ready(ready), .alert_oom(alert_oom), .state(state)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0, n_fail = 0, allow_cnt = 0;
  logic oom_exp = 1'b0;

  always @(posedge clk_i) if (allow_access === 1'b1) allow_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      W_ARV:    return arvalid;
      W_ALLOW:  return allow_access;
      W_TOLUPD: return tol_update;
      W_CTRIG:  return comp_trig;
      W_DTRIG:  return decomp_trig;
      W_KTRIG:  return compact_trig;
      W_READY:  return ready;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [51:0] rand52();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[51:0];
  endfunction

  task automatic group_drive(input int g, input logic on, input logic [63:0] a, input logic [7:0] l,
                             input logic [15:0] id, input logic [51:0] w);
    g_ar_addr[g] = a; g_arlen[g] = l; g_arvalid[g] = on; g_rready[g] = 1'b0;
    g_tol_update[g] = on; g_tol_att_id[g] = id; g_tol_way[g] = w; g_rdm_reset[g] = on;
  endtask

  // One-shot inputs are dropped at every step; bounded by a cycle budget
  task automatic wait_on(input int w, input string tag);
    int n = 0;
    do begin
      @(negedge clk_i);
      lookup = 0; compact_req = 0; rvalid = 0; rlast = 0;
      comp_done = 0; decomp_done = 0; tbl_update_done = 0; compact_done = 0;
      n++;
    end while (sig(w) !== 1'b1 && n < 64);
    chk({tag, "_seen"}, 64'(sig(w)), 64'd1);
  endtask

  task automatic answer_read(input string tag, input logic [63:0] exp_addr, input logic [1:0] st,
                             input logic [51:0] wy, input logic [1:0] resp);
    wait_on(W_ARV, tag);
    chk({tag, "_addr"}, ar_addr, exp_addr);
    chk({tag, "_arlen"}, 64'(arlen), 64'd0);
    chk({tag, "_rready"}, 64'(rready), 64'd1);
    for (int i = 0; i < DW / 32; i++) rdata[i*32 +: 32] = $urandom;
    rdata[63:62] = st; rdata[51:0] = wy;
    rvalid = 1; rlast = 1; rresp = resp;
  endtask

  // The sub-manager's request must appear on the outputs one cycle after it is driven
  task automatic mirror_chk(input int g, input string tag);
    logic [63:0] a; logic [7:0] l; logic [15:0] id; logic [51:0] w;
    a = {$urandom, $urandom}; l = 8'($urandom); id = 16'($urandom); w = rand52();
    group_drive(g, 1'b1, a, l, id, w);
    @(negedge clk_i);
    chk({tag, "_m_addr"}, ar_addr, a);
    chk({tag, "_m_arlen"}, 64'(arlen), 64'(l));
    chk({tag, "_m_arvalid"}, 64'(arvalid), 64'd1);
    chk({tag, "_m_rready"}, 64'(rready), 64'd0);
    chk({tag, "_m_tolupd"}, 64'(tol_update), 64'd1);
    chk({tag, "_m_tolid"}, 64'(tol_att_id), 64'(id));
    chk({tag, "_m_tolway"}, 64'(tol_way), 64'(w));
    chk({tag, "_m_rdm"}, 64'(rdm_reset), 64'd1);
    group_drive(g, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic run_txn(input string tag, input logic [15:0] off, input logic [1:0] st, input logic [51:0] aw,
                         input logic [15:0] fh, input logic unc_eq, input logic [51:0] tw, input logic [51:0] fw);
    logic [15:0] id; logic [63:0] exp_ppa; logic [1:0] exp_sts; int a0; logic oom;
    id = off + 16'd1;
    oom = 1'b0; exp_ppa = '0; exp_sts = '0;
    free_head = fh;
    unc_head = unc_eq ? 16'd7 : 16'd3;
    unc_tail = unc_eq ? 16'd7 : 16'd9;
    lookup_hppa = HBASE + 52'(off);
    lookup = 1;
    a0 = allow_cnt;
    answer_read({tag, "_att"}, 64'(id) * 64'd8, st, aw, 2'b00);
    chk({tag, "_no_compact"}, 64'(compact_trig), 64'd0);
    if (st == 2'd1 || st == 2'd3) begin
      exp_ppa = {aw, 12'h000}; exp_sts = st;
      wait_on(W_ALLOW, {tag, "_hit"});
    end else if (fh != 16'd0) begin
      answer_read({tag, "_tol"}, TOLB + 64'(fh) * 64'd8, 2'd0, tw, 2'b00);
      if (st == 2'd2) begin
        wait_on(W_DTRIG, {tag, "_dcmp"});
        chk({tag, "_dfree"}, decomp_freeway, {tw, 12'h000});
        chk({tag, "_dsrc"}, 64'(decomp_src_pg), 64'(aw));
        mirror_chk(1, tag);
        decomp_done = 1;
      end
      wait_on(W_TOLUPD, {tag, "_tolupd"});
      chk({tag, "_tol_id"}, 64'(tol_att_id), 64'(id));
      chk({tag, "_tol_way"}, 64'(tol_way), 64'(tw));
      tbl_update_done = 1;
      exp_ppa = {tw, 12'h000}; exp_sts = 2'd1;
      wait_on(W_ALLOW, {tag, "_alloc"});
    end else if (!unc_eq) begin
      wait_on(W_CTRIG, {tag, "_comp"});
      mirror_chk(0, tag);
      comp_freeway = fw; comp_done = 1;
      if (st == 2'd2) begin
        wait_on(W_DTRIG, {tag, "_cdcmp"});
        chk({tag, "_cdfree"}, decomp_freeway, {fw, 12'h000});
        decomp_done = 1;
      end
      exp_ppa = {fw, 12'h000}; exp_sts = 2'd1;
      wait_on(W_ALLOW, {tag, "_callow"});
    end else begin
      oom = 1'b1; oom_exp = 1'b1;
    end
    if (!oom) begin
      chk({tag, "_ppa"}, trnsl_ppa, exp_ppa);
      chk({tag, "_sts"}, 64'(trnsl_sts), 64'(exp_sts));
    end
    wait_on(W_READY, {tag, "_idle"});
    @(negedge clk_i);
    chk({tag, "_oom"}, 64'(alert_oom), 64'(oom_exp));
    chk({tag, "_allow_cnt"}, 64'(allow_cnt - a0), oom ? 64'd0 : 64'd1);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) group_drive(g, 1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk_i);
    chk("rst_ar_addr", ar_addr, 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_ppa", trnsl_ppa, 64'd0);
    chk("rst_allow", 64'(allow_access), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_oom", 64'(alert_oom), 64'd0);
    rst_ni = 1'b1;

    compact_req = 1; sw_ctrl = 2'd2;  // lookup must win over a simultaneous compaction request
    run_txn("hit", 16'd4, 2'd1, 52'h123, 16'd0, 1'b1, 52'h0, 52'h0);
    sw_ctrl = 2'd0;
    run_txn("free", 16'd0, 2'd0, 52'h999, 16'd5, 1'b1, 52'h77, 52'h0);
    run_txn("freecmp", 16'd2, 2'd2, 52'hABC, 16'd9, 1'b1, 52'h55, 52'h0);
    run_txn("comp", 16'd7, 2'd0, 52'h31, 16'd0, 1'b0, 52'h0, 52'h44);
    run_txn("compcmp", 16'd8, 2'd2, 52'h32, 16'd0, 1'b0, 52'h0, 52'h66);
    run_txn("incomp", 16'd3, 2'd3, 52'hFFFFF_FFFFFFFF, 16'd0, 1'b1, 52'h0, 52'h0);
    run_txn("wrap", 16'hFFFF, 2'd1, 52'h42, 16'd0, 1'b1, 52'h0, 52'h0);
    run_txn("oom", 16'd11, 2'd0, 52'h5, 16'd0, 1'b1, 52'h0, 52'h0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] fh;
      fh = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 16'hFFFF));
      run_txn($sformatf("rnd%0d", t), 16'($urandom), 2'($urandom_range(0, 3)), rand52(),
              fh, 1'($urandom_range(0, 1)), rand52(), rand52());
    end

    lookup_hppa = HBASE; lookup = 1;
    answer_read("berr_att", 64'd8, 2'd1, 52'h1, 2'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      rvalid = 0; rlast = 0; lookup = 1;
      chk("berr_ready", 64'(ready), 64'd0);
      chk("berr_arvalid", 64'(arvalid), 64'd0);
    end
    lookup = 0; rst_ni = 1'b0; oom_exp = 1'b0;
    #1;
    chk("rst2_ready", 64'(ready), 64'd1);
    chk("rst2_oom", 64'(alert_oom), 64'd0);
    chk("rst2_ppa", trnsl_ppa, 64'd0);
    chk("rst2_tolid", 64'(tol_att_id), 64'd0);
    chk("rst2_dfree", decomp_freeway, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    sw_ctrl = 2'd0;
    for (int i = 0; i < 4; i++) begin
      compact_req = 1;
      @(negedge clk_i);
      chk("cpt_gated", 64'(compact_trig), 64'd0);
    end
    sw_ctrl = 2'd2; compact_req = 1;
    wait_on(W_KTRIG, "cpt");
    mirror_chk(2, "cpt");
    chk("cpt_busy", 64'(ready), 64'd0);
    compact_done = 1;
    wait_on(W_READY, "cpt_exit");
    chk("cpt_trig_low", 64'(compact_trig), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
